// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Op encodings, FSM states, store lane steering and load normalization.
package dcache_pkg;

    localparam logic [3:0] OP_LB  = 4'b1000;
    localparam logic [3:0] OP_LH  = 4'b1001;
    localparam logic [3:0] OP_LW  = 4'b1010;
    localparam logic [3:0] OP_SB  = 4'b1011;
    localparam logic [3:0] OP_LBU = 4'b1100;
    localparam logic [3:0] OP_LHU = 4'b1101;
    localparam logic [3:0] OP_SH  = 4'b1110;
    localparam logic [3:0] OP_SW  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WTHRU,
        DONE
    } state_t;

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [3:0] st_strb(
        input logic [3:0] op,
        input logic [1:0] align
    );
        logic [3:0] s;
        s = 4'b0000;
        unique case (op)
            OP_SB:   s = 4'b0001 << align;
            OP_SH:   s = align[1] ? 4'b1100 : 4'b0011;
            OP_SW:   s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] st_data(
        input logic [3:0]  op,
        input logic [31:0] wd
    );
        logic [31:0] d;
        d = wd;
        unique case (op)
            OP_SB:   d = {4{wd[7:0]}};
            OP_SH:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // align[0] is ignored for halves and all of align for words
    function automatic logic [31:0] ld_norm(
        input logic [3:0]  op,
        input logic [1:0]  align,
        input logic [31:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[8*align +: 8];
        h = align[1] ? word[31:16] : word[15:0];
        r = word;
        unique case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for the direct-mapped data cache.
// Combinational lookup, byte-strobed write, valid bits cleared on reset.
module dcache_array #(
    parameter  int LINES   = 64,
    localparam int INDEX_W = $clog2(LINES),
    localparam int TAG_W   = 30 - INDEX_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0]   rd_tag_i,
    output logic               hit_o,
    output logic [31:0]        rd_data_o,
    input  logic               we_i,
    input  logic               fill_i,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [3:0]         wr_strb_i,
    input  logic [31:0]        wr_data_i
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (we_i && fill_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Contents need no reset: a line is only read once its valid bit is set
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            if (fill_i) begin
                tag_q[wr_idx_i] <= wr_tag_i;
            end
            for (int b = 0; b < 4; b++) begin
                if (wr_strb_i[b]) begin
                    data_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-through no-write-allocate data cache controller.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter  int LINES   = 64,
    localparam int INDEX_W = $clog2(LINES),
    localparam int TAG_W   = 30 - INDEX_W
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] req_addr_i,
    input  logic [3:0]  op_type_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        resp_valid_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    state_t state_q, state_d;

    logic [31:0] addr_q;
    logic [3:0]  op_q;
    logic        hit_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic [31:0] rdata_q;

    logic        is_mem;
    logic        is_st;
    logic        lk_hit;
    logic [31:0] lk_data;
    logic        mem_done;

    logic        arr_we;
    logic        arr_fill;
    logic [3:0]  arr_strb;
    logic [31:0] arr_wdata;

    assign is_mem   = op_type_i[3];
    assign is_st    = is_store(op_type_i);
    assign mem_done = mem_req_q && mem_ready_i;

    // Refill writes a whole line; a store only merges into a line it hit
    assign arr_fill  = (state_q == REFILL);
    assign arr_we    = !rst_i && mem_done
                     && (arr_fill || ((state_q == WTHRU) && hit_q));
    assign arr_strb  = arr_fill ? 4'b1111 : mem_wstrb_q;
    assign arr_wdata = arr_fill ? mem_rdata_i : mem_wdata_q;

    dcache_array #(
        .LINES (LINES)
    ) u_array (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rd_idx_i  (req_addr_i[INDEX_W+1:2]),
        .rd_tag_i  (req_addr_i[31:INDEX_W+2]),
        .hit_o     (lk_hit),
        .rd_data_o (lk_data),
        .we_i      (arr_we),
        .fill_i    (arr_fill),
        .wr_idx_i  (addr_q[INDEX_W+1:2]),
        .wr_tag_i  (addr_q[31:INDEX_W+2]),
        .wr_strb_i (arr_strb),
        .wr_data_i (arr_wdata)
    );

    always_comb begin
        state_d      = state_q;
        stall_o      = 1'b0;
        resp_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (is_mem && !rst_i) begin
                    stall_o = 1'b1;
                    if (is_st) begin
                        state_d = WTHRU;
                    end else if (lk_hit) begin
                        state_d = DONE;
                    end else begin
                        state_d = REFILL;
                    end
                end
            end
            REFILL, WTHRU: begin
                stall_o = 1'b1;
                if (mem_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_valid_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            op_q        <= '0;
            hit_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (is_mem) begin
                        addr_q      <= req_addr_i;
                        op_q        <= op_type_i;
                        hit_q       <= lk_hit;
                        mem_addr_q  <= {req_addr_i[31:2], 2'b00};
                        mem_wdata_q <= st_data(op_type_i, wdata_i);
                        mem_wstrb_q <= st_strb(op_type_i, req_addr_i[1:0]);
                        mem_we_q    <= is_st;
                        mem_req_q   <= is_st || !lk_hit;
                        if (!is_st && lk_hit) begin
                            rdata_q <= ld_norm(op_type_i, req_addr_i[1:0],
                                               lk_data);
                        end
                    end
                end
                REFILL: begin
                    if (mem_done) begin
                        mem_req_q <= 1'b0;
                        rdata_q   <= ld_norm(op_q, addr_q[1:0], mem_rdata_i);
                    end
                end
                WTHRU: begin
                    if (mem_done) begin
                        mem_req_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if ((state_q == IDLE) && is_mem && !is_st) begin
            if (lk_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

    assign rdata_o     = rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wstrb_o = mem_wstrb_q;

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Direct-mapped, write-through, no-write-allocate data cache controller between the core's memory stage and a single-word main-memory port.
- Each line holds one 32-bit word.
- Sequences lookups, refills on load miss and write-through on stores.
- Performs byte-lane steering and sign/zero extension using the core's 4-bit op_type encoding.
- Stalls the pipeline until each access completes.

Parameters:
LINES, 64, number of cache lines (power of two, >=2); INDEX_W = log2(LINES)
TAG_W, derived, 30 - INDEX_W, tag width (not user-settable)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
req_addr_i  in  32  byte address; [1:0]=align, [INDEX_W+1:2]=index, [31:INDEX_W+2]=tag
op_type_i  in  4  bit3=memory op; loads 1000 LB, 1001 LH, 1010 LW, 1100 LBU, 1101 LHU; stores 1011 SB, 1110 SH, 1111 SW; others = no-op
wdata_i  in  32  store data, LSB-aligned from register file
stall_o  out  1  core must hold req/op/wdata stable while high
resp_valid_o  out  1  one-cycle pulse: access completed
rdata_o  out  32  normalized load data, valid with resp_valid_o
mem_req_o  out  1  memory request, held until mem_ready_i
mem_we_o  out  1  1=write, 0=read
mem_addr_o  out  32  word address ({addr[31:2],2'b00})
mem_wdata_o  out  32  lane-replicated store data
mem_wstrb_o  out  4  byte strobes
mem_rdata_i  in  32  read data, valid when mem_ready_i
mem_ready_i  in  1  memory completion, sampled only while mem_req_o=1

Behaviour:
- Reset: state=IDLE; all valid bits cleared; stall_o=0, resp_valid_o=0, mem_req_o=0, mem_we_o=0, rdata_o=0. Tag/data contents are don't-care.
- States: IDLE, REFILL, WTHRU, DONE.
- IDLE, op_type_i[3]=0: no action, stall_o=0.
- IDLE, load hit (valid[idx] && tag match, combinational lookup):
  - stall_o=1 for the request cycle; go to DONE.
  - rdata_o registered from the cached word.
  - Net load-hit latency is 1 stall cycle.
- IDLE, load miss: stall_o=1; go to REFILL.
- IDLE, any store: stall_o=1; go to WTHRU.
- REFILL:
  - mem_req_o=1, mem_we_o=0.
  - On mem_ready_i: write mem_rdata_i to data[idx], write tag, set valid[idx]; register normalized rdata_o; go to DONE.
- WTHRU:
  - mem_req_o=1, mem_we_o=1; strobes SB=0001<<align, SH=align[1]?1100:0011, SW=1111.
  - mem_wdata_o: SB={4{wdata[7:0]}}, SH={2{wdata[15:0]}}, SW=wdata.
  - On mem_ready_i: if hit, merge strobed bytes into data[idx]; on miss no allocation. Go to DONE.
- DONE: resp_valid_o=1, stall_o=0; return to IDLE next cycle. Back-to-back requests are accepted from IDLE only.
- Load normalization:
  - byte = lane align; half = align[1] ? [31:16] : [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passthrough.
  - align[0] is ignored for halfwords; align is ignored for words. No misalignment trap.
- mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o and mem_wstrb_o are registered and stable while mem_req_o=1.
- mem_ready_i asserted while mem_req_o=0 is ignored.
- Reset mid-REFILL/WTHRU:
  - mem_req_o drops the next cycle, no cache update, no resp_valid_o.
  - The memory side must tolerate an abandoned request.
- Reserved op_type with bit3=1 (none exist in the encoding): treated as no-op.

Optional Feature:
DCACHE_STATS_EN:
- Defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
  - Load hits increment hit_cnt_o; load misses increment miss_cnt_o; both counted at IDLE acceptance.
  - Counters wrap at 2^32 and clear on rst_i.
  - Stores are not counted.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package dcache_pkg:
  - op_type localparams (OP_LB..OP_SW);
  - state enum (IDLE/REFILL/WTHRU/DONE);
  - helper functions for strobe generation and load normalization.
- Sub-module dcache_array: tag/valid/data flops, combinational read, byte-strobed write, valid clear on reset.
- The FSM and normalization stay in dcache_controller.

Test Plan:
1. Cold LW at 0x0000_0104, memory returns 0xDEAD_BEEF after 3 cycles -> mem_req_o 3 cycles, rdata_o=0xDEADBEEF with resp_valid_o; valid[1] set.
2. LB at 0x0000_0107 after test 1 -> hit, no mem_req_o, rdata_o=0xFFFFFFDE; LBU at 0x0000_0107 -> 0x000000DE.
3. SB 0x55 at 0x0000_0105 (hit) -> mem_wstrb_o=0010, mem_wdata_o=0x55555555; next LW at 0x0000_0104 -> 0xDEAD55EF without refill.
4. SH 0x1234 at 0x0000_2002 (miss) -> write-through with strobe 1100; next LH at 0x0000_2002 -> REFILL issued (no allocate).
5. Assert rst_i mid-REFILL -> mem_req_o=0 next cycle, no resp_valid_o; repeat of test 1's address -> miss again.
6. With DCACHE_STATS_EN: sequence 1 miss and 3 hits -> miss_cnt_o=1, hit_cnt_o=3; rst_i -> both 0.
